// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the block result-FIFO drain logic.
package fifo_drain_pkg;

   localparam int unsigned NBLOCKS     = 12;
   localparam int unsigned WORD_BITS   = 64;
   localparam int unsigned REQ_LATENCY = 2;
   localparam int unsigned HOLDOFF     = 2;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned CNT_W       = $clog2(WORD_BITS);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, HOLD, OUT} drain_state_t;

   typedef logic [IDX_W-1:0] blk_idx_t;
   typedef logic [1:NBLOCKS] blk_vec_t;

   typedef struct packed {
      blk_idx_t               index;
      logic [WORD_BITS-1:0]   data;
   } drain_word_t;

   // Block index base+off, wrapping NBLOCKS -> 1 (indices are 1-based).
   function automatic blk_idx_t blk_wrap(input blk_idx_t base, input int unsigned off);
      int unsigned s;
      s = ((32'(base) + off - 32'd1) % NBLOCKS) + 32'd1;
      return blk_idx_t'(s);
   endfunction

   function automatic blk_vec_t blk_onehot(input blk_idx_t idx);
      blk_vec_t v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fifo_drain_rr_arbiter.sv
// Round-robin first-set search over pending blocks, starting at the pointer.
module fifo_drain_rr_arbiter
   import fifo_drain_pkg::*;
(
   input  blk_vec_t pending,
   input  blk_idx_t ptr,
   output blk_idx_t grant_c,
   output logic     any_c
);

   // Lowest offset from the pointer wins; later hits are masked by any_c.
   always_comb begin
      grant_c = '0;
      any_c   = 1'b0;
      for (int unsigned off = 0; off < NBLOCKS; off++) begin
         if (!any_c && pending[blk_wrap(ptr, off)]) begin
            grant_c = blk_wrap(ptr, off);
            any_c   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_drain.sv
// Host-side reader: arbitrates non-empty blocks, pulses a request and
// deserialises the returned word onto a valid/ready port.
module fifo_drain
   import fifo_drain_pkg::*;
(
   input  logic                 fifo_clk,
   input  logic                 fifo_rst,
   input  logic [1:NBLOCKS]     fifo_empty,
   output logic [1:NBLOCKS]     fifo_req,
   input  logic                 fifo_bit,
   output logic [WORD_BITS-1:0] out_data,
   output logic [IDX_W-1:0]     out_index,
   output logic                 out_valid,
   input  logic                 out_ready
);

   drain_state_t           state;
   blk_idx_t               ptr;
   blk_idx_t               grant_q;
   logic [CNT_W-1:0]       cnt;
   logic [WORD_BITS-2:0]   shreg;
   drain_word_t            out_q;

   blk_vec_t               pending;
   blk_idx_t               grant_c;
   logic                   any_c;

   assign pending   = ~fifo_empty;
   assign out_data  = out_q.data;
   assign out_index = out_q.index;

   fifo_drain_rr_arbiter u_arb (
      .pending (pending),
      .ptr     (ptr),
      .grant_c (grant_c),
      .any_c   (any_c)
   );

   // Only one request is ever in flight, so the shared OR'd bit is never contended.
   always_ff @(posedge fifo_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         state     <= IDLE;
         ptr       <= blk_idx_t'(1);
         grant_q   <= '0;
         cnt       <= '0;
         shreg     <= '0;
         fifo_req  <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         fifo_req <= '0;
         unique case (state)
            IDLE: begin
               if (any_c) begin
                  grant_q  <= grant_c;
                  fifo_req <= blk_onehot(grant_c);
                  state    <= REQ;
               end
            end
            REQ: begin
               cnt   <= '0;
               state <= (REQ_LATENCY > 1) ? WAIT : SHIFT;
            end
            WAIT: begin
               if (cnt == CNT_W'(REQ_LATENCY - 2)) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHIFT: begin
               // LSB arrives first; shift right so bit 0 ends up at the bottom.
               if (cnt == CNT_W'(WORD_BITS - 1)) begin
                  out_q.data  <= {fifo_bit, shreg};
                  out_q.index <= grant_q;
                  out_valid   <= 1'b1;
                  cnt         <= '0;
                  state       <= OUT;
               end else begin
                  shreg <= {fifo_bit, shreg[WORD_BITS-2:1]};
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  ptr       <= blk_wrap(grant_q, 1);
                  cnt       <= '0;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               // Gives the served block time to update its empty flag.
               if (cnt == CNT_W'(HOLDOFF - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
